l1_lru_cache_controller: RTL and testbench

Sequencing controller for the L1 set-associative lookup/update datapath (find/update engine with replace handshake). Accepts one CPU read request at a time and pulses find_start. On a miss it fetches the block from the next level, then pulses update_start. When the engine raises replace, it supplies the LRU victim way. Per-set true-LRU age state lives here; the datapath holds only tags and data.

---
 rtl/l1_lru_cache_controller.sv | 165 ++++++++++++++++
 tb/tb_l1_lru_cache_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1_lru_cache_controller.sv
// Sequencing controller for the L1 find/update datapath: owns the request FSM,
// the next-level fetch and the per-set true-LRU ages used to pick victims.
module l1_lru_cache_controller #(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    localparam int OFFSET_W = $clog2(BLOCK_SIZE_BYTE),
    localparam int SET      = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    localparam int SET_W    = $clog2(SET),
    localparam int AGE_W    = $clog2(WAY),
    localparam int TAG_W    = 32 - SET_W - OFFSET_W,
    localparam int BLOCK_W  = BLOCK_SIZE_BYTE * 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [31:0]         req_addr,
    output logic                req_ready,
    output logic                resp_valid,
    output logic                resp_hit,
    output logic [TAG_W-1:0]    tag,
    output logic [SET_W-1:0]    index,
    output logic [OFFSET_W-1:0] block_offset,
    output logic                find_start,
    input  logic                find_done,
    input  logic                found_in_cache,
    input  logic [4:0]          cache_way_index,
    output logic                update_start,
    input  logic                replace,
    output logic                block_replace,
    output logic [4:0]          replace_way,
    input  logic                updated,
    output logic [BLOCK_W-1:0]  block,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    input  logic                mem_ack,
    input  logic [BLOCK_W-1:0]  mem_block,
    output logic [2:0]          state_dbg
);

    // Handshakes: a CPU request transfers on a cycle where req_valid && req_ready;
    // a fetch completes on the first cycle mem_ack is high while mem_req is high;
    // find_done/updated are single-cycle pulses honoured only in LOOKUP/FILL.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_HIT_RESP  = 3'd2,
        S_MEM       = 3'd3,
        S_FILL      = 3'd4,
        S_MISS_RESP = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [AGE_W-1:0] age [SET][WAY];
    logic [AGE_W-1:0] victim;
    logic [AGE_W-1:0] engine_way;
    logic [4:0]       engine_way_full;
    logic [AGE_W-1:0] touch_way;
    logic             touch_en;
    logic             accept;

    assign accept          = (state == S_IDLE) && req_valid && !rst;
    assign engine_way_full = cache_way_index - 5'd1;
    assign engine_way      = engine_way_full[AGE_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (req_valid) state_nxt = S_LOOKUP;
            S_LOOKUP:    if (find_done) state_nxt = found_in_cache ? S_HIT_RESP : S_MEM;
            S_MEM:       if (mem_ack) state_nxt = S_FILL;
            S_FILL:      if (updated) state_nxt = S_MISS_RESP;
            S_HIT_RESP:  state_nxt = S_IDLE;
            S_MISS_RESP: state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    assign req_ready  = (state == S_IDLE) && !rst;
    assign resp_valid = (state == S_HIT_RESP) || (state == S_MISS_RESP);
    assign resp_hit   = (state == S_HIT_RESP);
    assign mem_req    = (state == S_MEM);
    assign mem_addr   = {tag, index, {OFFSET_W{1'b0}}};
    assign state_dbg  = state;

    // Lowest-numbered way holding the oldest age; scanning downward lets the
    // lowest match overwrite higher ones.
    always_comb begin
        victim = '0;
        for (int w = WAY - 1; w >= 0; w--) begin
            if (age[index][w] == AGE_W'(WAY - 1)) victim = AGE_W'(w);
        end
    end

    always_comb begin
        touch_en  = 1'b0;
        touch_way = engine_way;
        if (state == S_LOOKUP && find_done && found_in_cache) begin
            touch_en = 1'b1;
        end else if (state == S_FILL && updated) begin
            touch_en = 1'b1;
            if (block_replace) touch_way = replace_way[AGE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag           <= '0;
            index         <= '0;
            block_offset  <= '0;
            block         <= '0;
            find_start    <= 1'b0;
            update_start  <= 1'b0;
            block_replace <= 1'b0;
            replace_way   <= '0;
        end else begin
            find_start   <= accept;
            update_start <= (state == S_MEM) && mem_ack;
            if (accept) begin
                tag          <= req_addr[31:SET_W+OFFSET_W];
                index        <= req_addr[SET_W+OFFSET_W-1:OFFSET_W];
                block_offset <= req_addr[OFFSET_W-1:0];
            end
            if (state == S_MEM && mem_ack) block <= mem_block;
            // updated wins over a coincident replace, so no victim command is issued
            if (state == S_FILL) begin
                if (updated) begin
                    block_replace <= 1'b0;
                end else if (replace && !block_replace) begin
                    block_replace <= 1'b1;
                    replace_way   <= {{(5 - AGE_W){1'b0}}, victim};
                end
            end else begin
                block_replace <= 1'b0;
            end
        end
    end

    // Touch: ways younger than the touched way age by one, touched way becomes 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET; s++) begin
                for (int w = 0; w < WAY; w++) begin
                    age[s][w] <= AGE_W'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAY; w++) begin
                if (AGE_W'(w) == touch_way) begin
                    age[index][w] <= '0;
                end else if (age[index][w] < age[index][touch_way]) begin
                    age[index][w] <= age[index][w] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_lru_cache_controller.sv
// Directed bench for l1_lru_cache_controller: plays the lookup/update engine and
// next-level memory, checking handshakes and LRU victim selection.
module tb_l1_lru_cache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         resp_valid;
    logic         resp_hit;
    logic [18:0]  tag;
    logic [8:0]   index;
    logic [3:0]   block_offset;
    logic         find_start;
    logic         find_done;
    logic         found_in_cache;
    logic [4:0]   cache_way_index;
    logic         update_start;
    logic         replace;
    logic         block_replace;
    logic [4:0]   replace_way;
    logic         updated;
    logic [127:0] block;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [127:0] mem_block;
    logic [2:0]   state_dbg;

    int n_vec = 0;
    int n_err = 0;

    l1_lru_cache_controller dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .tag(tag), .index(index), .block_offset(block_offset),
        .find_start(find_start), .find_done(find_done),
        .found_in_cache(found_in_cache), .cache_way_index(cache_way_index),
        .update_start(update_start), .replace(replace),
        .block_replace(block_replace), .replace_way(replace_way),
        .updated(updated), .block(block), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_block(mem_block),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int budget = 50;
        while (!req_ready && budget > 0) begin
            step();
            budget--;
        end
        check("wait_req_ready", req_ready, 1'b1);
    endtask

    // Accept a request and run the lookup; returns with the DUT in HIT_RESP or MEM.
    task automatic start_req(input logic [31:0] addr, input bit hit, input int way);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        check("find_start_pulse", find_start, 1'b1);
        check("req_ready_busy", req_ready, 1'b0);
        check("tag_latch", tag, addr[31:13]);
        check("index_latch", index, addr[12:4]);
        check("offset_latch", block_offset, addr[3:0]);
        step();
        check("find_start_drop", find_start, 1'b0);
        find_done       = 1'b1;
        found_in_cache  = hit;
        cache_way_index = 5'(way + 1);
        step();
        find_done      = 1'b0;
        found_in_cache = 1'b0;
    endtask

    task automatic access(input logic [31:0] addr, input bit hit, input int way,
                          input bit use_replace, input int exp_victim,
                          input int ack_delay, input logic [127:0] data);
        start_req(addr, hit, way);
        if (hit) begin
            check("hit_resp_valid", resp_valid, 1'b1);
            check("hit_resp_hit", resp_hit, 1'b1);
            check("hit_no_mem_req", mem_req, 1'b0);
        end else begin
            check("mem_req_up", mem_req, 1'b1);
            check("mem_addr", mem_addr, {addr[31:4], 4'h0});
            for (int i = 0; i < ack_delay; i++) begin
                step();
                check("mem_req_held", mem_req, 1'b1);
                check("mem_addr_stable", mem_addr, {addr[31:4], 4'h0});
                check("req_ready_in_mem", req_ready, 1'b0);
            end
            mem_ack   = 1'b1;
            mem_block = data;
            step();
            mem_ack   = 1'b0;
            mem_block = '0;
            check("update_start_pulse", update_start, 1'b1);
            check("mem_req_drop", mem_req, 1'b0);
            check("block_latch", block, data);
            step();
            check("update_start_drop", update_start, 1'b0);
            if (use_replace) begin
                replace = 1'b1;
                step();
                replace = 1'b0;
                check("block_replace_up", block_replace, 1'b1);
                check("replace_way", replace_way, 5'(exp_victim));
                step();
                step();
                check("block_replace_held", block_replace, 1'b1);
                check("replace_way_stable", replace_way, 5'(exp_victim));
                cache_way_index = 5'd0;
            end else begin
                cache_way_index = 5'(way + 1);
            end
            updated = 1'b1;
            step();
            updated = 1'b0;
            check("block_replace_clear", block_replace, 1'b0);
            check("miss_resp_valid", resp_valid, 1'b1);
            check("miss_resp_hit", resp_hit, 1'b0);
            check("block_hold_resp", block, data);
        end
        step();
        check("resp_valid_drop", resp_valid, 1'b0);
        check("req_ready_back", req_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] pat_a5;
        logic [127:0] pat_x;
        pat_a5 = {16{8'hA5}};
        pat_x  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; find_done = 1'b0;
        found_in_cache = 1'b0; cache_way_index = '0; replace = 1'b0;
        updated = 1'b0; mem_ack = 1'b0; mem_block = '0;
        repeat (3) step();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_find_start", find_start, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_block", block, '0);
        check("rst_mem_addr", mem_addr, '0);
        rst = 1'b0;
        step();
        check("ready_after_rst", req_ready, 1'b1);

        // Cold miss into set 1, engine fills invalid way0; then hit way0.
        access(32'h0000_0010, 1'b0, 0, 1'b0, 0, 2, pat_a5);
        access(32'h0000_0014, 1'b1, 0, 1'b0, 0, 0, '0);
        // Set 1 ages untouched by way0 fills: oldest is still way3.
        access(32'h0000_2010, 1'b0, 0, 1'b1, 3, 1, pat_x);

        // Set 0: fill ways 0..3, then a conflicting miss evicts way0.
        access(32'h0000_0000, 1'b0, 0, 1'b0, 0, 1, pat_x);
        access(32'h0000_2000, 1'b0, 1, 1'b0, 0, 1, pat_x);
        access(32'h0000_4000, 1'b0, 2, 1'b0, 0, 1, pat_x);
        access(32'h0000_6000, 1'b0, 3, 1'b0, 0, 1, pat_x);
        access(32'h0000_8000, 1'b0, 0, 1'b1, 0, 1, pat_a5);

        // Set 2: same fills, but a hit on way0 makes way1 the oldest.
        access(32'h0000_0020, 1'b0, 0, 1'b0, 0, 1, pat_x);
        access(32'h0000_2020, 1'b0, 1, 1'b0, 0, 1, pat_x);
        access(32'h0000_4020, 1'b0, 2, 1'b0, 0, 1, pat_x);
        access(32'h0000_6020, 1'b0, 3, 1'b0, 0, 1, pat_x);
        access(32'h0000_0020, 1'b1, 0, 1'b0, 0, 0, '0);
        access(32'h0000_8020, 1'b0, 0, 1'b1, 1, 1, pat_a5);

        // Slow next level: mem_req held 20 cycles.
        access(32'h0000_0030, 1'b0, 0, 1'b0, 0, 20, pat_x);

        // Reset while waiting on memory drops the request.
        start_req(32'h0000_0040, 1'b0, 0);
        check("pre_rst_mem_req", mem_req, 1'b1);
        step();
        rst = 1'b1;
        step();
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_mem_addr", mem_addr, '0);
        check("midrst_resp_valid", resp_valid, 1'b0);
        check("midrst_req_ready", req_ready, 1'b0);
        check("midrst_block", block, '0);
        check("midrst_tag", tag, '0);
        check("midrst_state", state_dbg, 3'd0);
        mem_ack = 1'b1;
        step();
        rst     = 1'b0;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst_no_resp", resp_valid, 1'b0);
            check("postrst_no_mem_req", mem_req, 1'b0);
        end
        // Ages are back to reset: victim order restarts at way3.
        access(32'h0000_0010, 1'b0, 0, 1'b1, 3, 1, pat_a5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
